// File: rtl/hamming_decoder_74_pkg.sv
// Shared Hamming(7,4) constants: widths and the position-to-bit mapping.
// Hamming position k (1..7) lives at code bit CODE_W-k.
package hamming_decoder_74_pkg;

  localparam int CODE_W = 7;
  localparam int DATA_W = 4;
  localparam int SYN_W  = 3;

  // Code bit index of each Hamming position
  localparam int P1_BIT = CODE_W - 1;
  localparam int P2_BIT = CODE_W - 2;
  localparam int D0_BIT = CODE_W - 3;
  localparam int P3_BIT = CODE_W - 4;
  localparam int D1_BIT = CODE_W - 5;
  localparam int D2_BIT = CODE_W - 6;
  localparam int D3_BIT = CODE_W - 7;

  // Code bits covered by each parity check (positions with that bit of k set)
  localparam logic [CODE_W-1:0] S1_MASK = 7'b1010101;
  localparam logic [CODE_W-1:0] S2_MASK = 7'b0110011;
  localparam logic [CODE_W-1:0] S3_MASK = 7'b0001111;

  function automatic logic [DATA_W-1:0] extract_data(input logic [CODE_W-1:0] c);
    return {c[D3_BIT], c[D2_BIT], c[D1_BIT], c[D0_BIT]};
  endfunction

  function automatic logic [CODE_W-1:0] encode(input logic [DATA_W-1:0] d);
    logic [CODE_W-1:0] c;
    c         = '0;
    c[D0_BIT] = d[0];
    c[D1_BIT] = d[1];
    c[D2_BIT] = d[2];
    c[D3_BIT] = d[3];
    c[P1_BIT] = ^(c & S1_MASK);
    c[P2_BIT] = ^(c & S2_MASK);
    c[P3_BIT] = ^(c & S3_MASK);
    return c;
  endfunction

endpackage

// File: rtl/hamming74_syndrome.sv
// Combinational Hamming(7,4) syndrome, single-bit correction and data extraction.
module hamming74_syndrome
  import hamming_decoder_74_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [SYN_W-1:0]  syndrome,
  output logic [DATA_W-1:0] data
);

  logic [CODE_W-1:0] corrected;

  always_comb begin
    syndrome  = {^(code & S3_MASK), ^(code & S2_MASK), ^(code & S1_MASK)};
    corrected = code;
    // A nonzero syndrome names the Hamming position to invert
    for (int k = 1; k <= CODE_W; k++) begin
      if (syndrome == k[SYN_W-1:0]) begin
        corrected[CODE_W-k] = ~code[CODE_W-k];
      end
    end
    data = extract_data(corrected);
  end

endmodule

// File: rtl/hamming_decoder_74.sv
// Two-stage Hamming(7,4) decoder with valid/ready flow control and a saturating
// corrected-word counter.
module hamming_decoder_74
  import hamming_decoder_74_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [6:0]        code_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic [3:0]        data_out,
  output logic              valid_out,
  input  logic              ready_in,
  output logic [2:0]        syndrome_out,
  output logic              err_corrected,
  output logic [CNT_W-1:0]  corr_count,
  input  logic              clear_count
);

  // Handshake: a word moves on every edge where valid and ready are both high.
  // adv stalls the whole pipeline; ready_out is adv with no register in between.
  logic              adv;
  logic              inc;

  logic              s1_valid_q, s1_valid_d;
  logic [CODE_W-1:0] s1_code_q,  s1_code_d;
  logic              valid_out_q, valid_out_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [SYN_W-1:0]  syn_q, syn_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [SYN_W-1:0]  syn_comb;
  logic [DATA_W-1:0] data_comb;

  hamming74_syndrome u_syndrome (
    .code     (s1_code_q),
    .syndrome (syn_comb),
    .data     (data_comb)
  );

  always_comb begin
    adv         = ena & (~valid_out_q | ready_in);
    s1_valid_d  = s1_valid_q;
    s1_code_d   = s1_code_q;
    valid_out_d = valid_out_q;
    data_d      = data_q;
    syn_d       = syn_q;
    err_d       = err_q;
    if (adv) begin
      s1_valid_d  = valid_in;
      s1_code_d   = code_in;
      valid_out_d = s1_valid_q;
      data_d      = data_comb;
      syn_d       = syn_comb;
      err_d       = s1_valid_q & (|syn_comb);
    end
  end

  // Clear wins over a same-cycle increment; the counter never wraps
  always_comb begin
    inc     = valid_out_q & ready_in & err_q & ena;
    count_d = count_q;
    if (clear_count) begin
      count_d = '0;
    end else if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_code_q   <= '0;
      valid_out_q <= 1'b0;
      data_q      <= '0;
      syn_q       <= '0;
      err_q       <= 1'b0;
      count_q     <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_code_q   <= s1_code_d;
      valid_out_q <= valid_out_d;
      data_q      <= data_d;
      syn_q       <= syn_d;
      err_q       <= err_d;
      count_q     <= count_d;
    end
  end

  assign ready_out     = adv;
  assign valid_out     = valid_out_q;
  assign data_out      = data_q;
  assign syndrome_out  = syn_q;
  assign err_corrected = err_q;
  assign corr_count    = count_q;

endmodule

// File: tb/tb_hamming_decoder_74.sv
// Randomized and directed bench for hamming_decoder_74 with an expected-response queue.
module tb_hamming_decoder_74;

  localparam int CNT_W   = 8;
  localparam int CNT_MAX = 255;

  logic             clk;
  logic             rst;
  logic             ena;
  logic [6:0]       code_in;
  logic             valid_in;
  logic             ready_out;
  logic [3:0]       data_out;
  logic             valid_out;
  logic             ready_in;
  logic [2:0]       syndrome_out;
  logic             err_corrected;
  logic [CNT_W-1:0] corr_count;
  logic             clear_count;

  int tests = 0;
  int fails = 0;

  // expected entry: {syndrome[7:5], err[4], data[3:0]}
  logic [7:0] exp_q[$];
  logic [7:0] cur_exp;
  int         exp_count;

  logic rand_mode = 1'b0;
  logic rdy_ctl   = 1'b1;
  logic ena_ctl   = 1'b1;
  logic clr_ctl   = 1'b0;

  hamming_decoder_74 #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .ena           (ena),
    .code_in       (code_in),
    .valid_in      (valid_in),
    .ready_out     (ready_out),
    .data_out      (data_out),
    .valid_out     (valid_out),
    .ready_in      (ready_in),
    .syndrome_out  (syndrome_out),
    .err_corrected (err_corrected),
    .corr_count    (corr_count),
    .clear_count   (clear_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Bits held by Hamming position (1..7); position k sits at code bit 7-k.
  function automatic logic [6:0] model_encode(input logic [3:0] nib);
    logic [7:0] b;
    logic [6:0] c;
    b = '0;
    b[3] = nib[0]; b[5] = nib[1]; b[6] = nib[2]; b[7] = nib[3];
    for (int p = 1; p <= 4; p = p * 2)
      for (int k = 1; k <= 7; k++)
        if ((k & p) != 0 && k != p) b[p] = b[p] ^ b[k];
    for (int k = 1; k <= 7; k++) c[7-k] = b[k];
    return c;
  endfunction

  // Syndrome is the XOR of the positions of all set bits
  function automatic logic [7:0] model_decode(input logic [6:0] c);
    logic [7:0] b;
    int s;
    s = 0;
    b = '0;
    for (int k = 1; k <= 7; k++) begin
      b[k] = c[7-k];
      if (b[k]) s = s ^ k;
    end
    if (s != 0) b[s] = ~b[s];
    return {s[2:0], (s != 0), b[7], b[6], b[5], b[3]};
  endfunction

  // ---------------- input knobs ----------------
  initial begin
    ready_in    = 1'b1;
    ena         = 1'b1;
    clear_count = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (rand_mode) begin
        ready_in    = ($urandom_range(0, 3) != 0);
        ena         = ($urandom_range(0, 7) != 0);
        clear_count = ($urandom_range(0, 40) == 0);
      end else begin
        ready_in    = rdy_ctl;
        ena         = ena_ctl;
        clear_count = clr_ctl;
      end
    end
  end

  // ---------------- driver ----------------
  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [6:0] code, input logic [3:0] ed, input logic [2:0] es);
    logic acc;
    int   n;
    code_in  = code;
    valid_in = 1'b1;
    cur_exp  = {es, (es != 3'd0), ed};
    n = 0;
    acc = 1'b0;
    while (!acc && n < 300) begin
      @(negedge clk);
      acc = ready_out;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check("send_timeout", 32'd0, 32'd1);
    valid_in = 1'b0;
  endtask

  task automatic send_model(input logic [6:0] code);
    logic [7:0] e;
    e = model_decode(code);
    send(code, e[3:0], e[7:5]);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic       rst_prev  = 1'b1;
  logic       hold_prev = 1'b0;
  logic [3:0] prev_data;
  logic [2:0] prev_syn;
  logic       prev_err;

  initial begin
    logic [7:0] e;
    logic       xfer;
    logic       inc;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (rst_prev) begin
        check("rst_valid_out", valid_out, 0);
        check("rst_data_out", data_out, 0);
        check("rst_syndrome", syndrome_out, 0);
        check("rst_err", err_corrected, 0);
        check("rst_count", corr_count, 0);
      end
      check("ready_out", ready_out, ena & (~valid_out | ready_in));
      if (!valid_out) check("err_idle", err_corrected, 0);
      if (hold_prev) begin
        check("stall_data", data_out, prev_data);
        check("stall_syn", syndrome_out, prev_syn);
        check("stall_err", err_corrected, prev_err);
      end
      check("corr_count", corr_count, exp_count);
      xfer = valid_out & ready_in & ena & ~rst;
      inc  = 1'b0;
      if (xfer) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("data_out", data_out, e[3:0]);
          check("syndrome_out", syndrome_out, e[7:5]);
          check("err_corrected", err_corrected, e[4]);
          inc = e[4];
        end
      end
      if (rst) begin
        exp_q.delete();
        exp_count = 0;
      end else begin
        if (clear_count) exp_count = 0;
        else if (inc && exp_count < CNT_MAX) exp_count++;
        if (valid_in && ready_out) exp_q.push_back(cur_exp);
      end
      hold_prev = valid_out & ~ready_in & ~rst;
      prev_data = data_out;
      prev_syn  = syndrome_out;
      prev_err  = err_corrected;
      rst_prev  = rst;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] nib;
    logic [6:0] c;
    int p1, p2;
    exp_count = 0;
    rst      = 1'b1;
    valid_in = 1'b0;
    code_in  = '0;
    cur_exp  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // directed: clean, data-bit error, parity-bit error
    send_model(7'h55);
    send_model(7'h54);
    send_model(7'h40);
    drain();
    check("dir_count_two_errors", corr_count, 2);

    // every nibble with every single-bit flip
    for (int n = 0; n < 16; n++) begin
      for (int pos = 1; pos <= 7; pos++) begin
        nib = n[3:0];
        c = model_encode(nib) ^ (7'd1 << (7 - pos));
        send(c, nib, pos[2:0]);
      end
    end
    drain();

    // backpressure: ready_in low for three stalled cycles
    rdy_ctl = 1'b0;
    fork
      begin
        send_model(7'h55);
        send_model(7'h54);
        send_model(7'h00);
      end
      begin
        repeat (2) @(posedge clk);
        #2;
        for (int i = 0; i < 3; i++) begin
          check("bp_ready_out", ready_out, 0);
          check("bp_valid_out", valid_out, 1);
          @(posedge clk);
          #2;
        end
        rdy_ctl = 1'b1;
      end
    join
    drain();

    // randomized traffic with clean, single and double errors
    rand_mode = 1'b1;
    for (int i = 0; i < 250; i++) begin
      c = model_encode(4'($urandom_range(0, 15)));
      case ($urandom_range(0, 2))
        0: ;
        1: c = c ^ (7'd1 << $urandom_range(0, 6));
        default: begin
          p1 = $urandom_range(0, 6);
          p2 = (p1 + $urandom_range(1, 6)) % 7;
          c = c ^ (7'd1 << p1) ^ (7'd1 << p2);
        end
      endcase
      send_model(c);
    end
    rand_mode = 1'b0;
    @(posedge clk);
    #1;
    drain();

    // saturation
    for (int i = 0; i < 300; i++) begin
      c = model_encode(4'($urandom_range(0, 15))) ^ (7'd1 << $urandom_range(0, 6));
      send_model(c);
    end
    drain();
    check("sat_count", corr_count, CNT_MAX);

    // reset with two words in flight
    rdy_ctl = 1'b0;
    @(posedge clk);
    #1;
    send_model(7'h54);
    send_model(7'h40);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rdy_ctl = 1'b1;
    #2;
    check("midrst_valid_out", valid_out, 0);
    check("midrst_count", corr_count, 0);
    repeat (6) @(posedge clk);
    #1;

    // clear together with an increment
    send_model(7'h54);
    drain();
    check("pre_clear_count", corr_count, 1);
    rdy_ctl = 1'b0;
    send_model(7'h54);
    repeat (2) @(posedge clk);
    #1;
    rdy_ctl = 1'b1;
    clr_ctl = 1'b1;
    @(posedge clk);
    #1;
    clr_ctl = 1'b0;
    #2;
    check("clear_vs_inc", corr_count, 0);
    drain();

    // enable low: pipeline frozen, ready_out low, clear still acts
    send_model(7'h54);
    drain();
    rdy_ctl = 1'b0;
    send_model(7'h40);
    @(posedge clk);
    #1;
    ena_ctl = 1'b0;
    clr_ctl = 1'b1;
    @(posedge clk);
    #3;
    check("ena_low_ready", ready_out, 0);
    check("ena_low_clear", corr_count, 0);
    clr_ctl = 1'b0;
    rdy_ctl = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    check("ena_low_hold_valid", valid_out, 1);
    ena_ctl = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3000000;
    fails++;
    $display("FAIL global_timeout: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
